// File: rtl/bcd_down_counter2_pkg.sv
// Shared definitions for the two-digit BCD down-counter: digit type,
// BCD limits and the clamp / decrement helpers used by each digit cell.
// Pure definitions, no logic or state.
package bcd_down_counter2_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    typedef logic [3:0] bcd_digit_t;

    // Limit a load value to the largest legal BCD digit.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t in);
        return (in > BCD_MAX) ? BCD_MAX : in;
    endfunction

    // One-step down-count of a digit. Zero wraps to nine. A non-BCD value
    // (10-15) simply steps down in binary until it re-enters the legal range.
    function automatic bcd_digit_t bcd_dec(input bcd_digit_t d);
        return (d == BCD_ZERO) ? BCD_MAX : bcd_digit_t'(d - 4'd1);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// Single BCD down-count digit cell with load, clear and borrow-out.
// Latency: digit updates one cycle after Clear/Load/count; borrow/zero_d are combinational.
// Backpressure: none; count is a plain enable, borrow is asserted whenever this digit underflows.
module bcd_down_digit
    import bcd_down_counter2_pkg::*;
#(
    parameter bit CLAMP_LOAD = 1'b1
) (
    input  logic       CLK,
    input  logic       Clear,
    input  logic [3:0] Din,
    input  logic       Load,
    input  logic       count,
    output logic [3:0] DO,
    output logic       borrow,
    output logic       zero_d
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;
    bcd_digit_t load_val;

    // Load value, optionally forced into the legal BCD range.
    always_comb begin
        load_val = CLAMP_LOAD ? bcd_clamp(Din) : Din;
    end

    // Next digit: Load beats count; a count from zero wraps to nine.
    always_comb begin
        digit_d = digit_q;
        if (Load) begin
            digit_d = load_val;
        end else if (count) begin
            digit_d = bcd_dec(digit_q);
        end
    end

    // Digit register; Clear forces zero regardless of Load/count.
    always_ff @(posedge CLK) begin
        if (Clear) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Borrow only when this cycle really decrements through zero, so a
    // Load or Clear in the same cycle never leaks a spurious borrow.
    always_comb begin
        zero_d = (digit_q == BCD_ZERO);
        borrow = count & ~Load & ~Clear & zero_d;
    end

    assign DO = digit_q;

endmodule

// File: rtl/bcd_down_counter2.sv
// Two-digit BCD down-counter (A = ones, B = tens) built from chained digit cells.
// Latency: AO/BO one cycle after Clear/Load/count; zero and borrowOut are combinational on the registered digits.
// Backpressure: none; borrowOut cascades to further digits and repeats every counted cycle at 00 when holding.
module bcd_down_counter2
    import bcd_down_counter2_pkg::*;
#(
    parameter bit WRAP       = 1'b1,
    parameter bit CLAMP_LOAD = 1'b1
) (
    input  logic       CLK,
    input  logic       Clear,
    input  logic [3:0] Ain,
    input  logic [3:0] Bin,
    input  logic       Load,
    input  logic       count,
    output logic [3:0] AO,
    output logic [3:0] BO,
    output logic       borrowOut,
    output logic       zero
);

    logic zero_a;
    logic zero_b;
    logic borrow_a;
    logic borrow_b;
    logic count_eff;

    // Without wrap, 00 is terminal: stop feeding count into the cells so the
    // digits hold, while borrowOut below still reports the attempted count.
    always_comb begin
        count_eff = count;
        if (!WRAP && zero_a && zero_b) begin
            count_eff = 1'b0;
        end
    end

    bcd_down_digit #(
        .CLAMP_LOAD (CLAMP_LOAD)
    ) u_digit_a (
        .CLK    (CLK),
        .Clear  (Clear),
        .Din    (Ain),
        .Load   (Load),
        .count  (count_eff),
        .DO     (AO),
        .borrow (borrow_a),
        .zero_d (zero_a)
    );

    // Tens digit steps only on a ones-digit underflow.
    bcd_down_digit #(
        .CLAMP_LOAD (CLAMP_LOAD)
    ) u_digit_b (
        .CLK    (CLK),
        .Clear  (Clear),
        .Din    (Bin),
        .Load   (Load),
        .count  (borrow_a),
        .DO     (BO),
        .borrow (borrow_b),
        .zero_d (zero_b)
    );

    // Cascade borrow is taken from the raw count so it stays asserted at a
    // held 00; the tens-cell borrow alone would be masked by the hold gating.
    always_comb begin
        zero      = zero_a & zero_b;
        borrowOut = count & ~Load & ~Clear & zero;
    end

    // The tens-cell borrow matches borrowOut whenever the counter wraps; it is
    // not needed as an output because borrowOut covers both wrap modes.
    logic unused_borrow_b;
    assign unused_borrow_b = borrow_b;

endmodule
